asym_dpram: RTL and testbench

ASYM_DPRAM -- requirements
Module: asym_dpram

---
 rtl/ram_pkg.sv | 12 +
 rtl/asym_dpram_if.sv | 18 +
 rtl/asym_dpram_port.sv | 37 +++
 rtl/asym_dpram.sv | 46 ++++
 tb/tb_asym_dpram.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: write-mode constants and a clog2 helper shared by the RAM blocks.
package ram_pkg;
    localparam int MODE_WRITE_FIRST = 0;
    localparam int MODE_READ_FIRST = 1;
    localparam int MODE_NO_CHANGE = 2;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/asym_dpram_if.sv
// asym_dpram_if: signal bundle for the narrow port A and the wide port B.
interface asym_dpram_if #(
    parameter int WIDTH_A = 1,
    parameter int RATIO = 32,
    parameter int DEPTH_B = 512
);
    localparam int WIDTH_B = WIDTH_A * RATIO;
    localparam int ADDR_A = ram_pkg::clog2(DEPTH_B * RATIO);
    localparam int ADDR_B = ram_pkg::clog2(DEPTH_B);
    logic [WIDTH_A-1:0] dia, doa;
    logic [ADDR_A-1:0] addra;
    logic ena, wea, ssra;
    logic [WIDTH_B-1:0] dib, dob;
    logic [ADDR_B-1:0] addrb;
    logic enb, web, ssrb;
    modport master(output dia, addra, ena, wea, ssra, dib, addrb, enb, web, ssrb, input doa, dob);
    modport slave(input dia, addra, ena, wea, ssra, dib, addrb, enb, web, ssrb, output doa, dob);
endinterface

// File: rtl/asym_dpram_port.sv
// asym_dpram_port: one port's output stage -- write-mode select, sync set/reset and,
// with ASYM_DPRAM_DOREG_EN defined, an extra output register.
module asym_dpram_port
    import ram_pkg::*;
#(
    parameter int W = 1,
    parameter int MODE = MODE_WRITE_FIRST,
    parameter logic [W-1:0] SRVAL = '0
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         en,
    input  logic         we,
    input  logic         ssr,
    input  logic [W-1:0] wr_data,
    input  logic [W-1:0] rd_data,
    output logic [W-1:0] dout
);
    logic hold;
    logic [W-1:0] sel, s1;
    assign hold = we && MODE == MODE_NO_CHANGE;
    assign sel = (we && MODE == MODE_WRITE_FIRST) ? wr_data : rd_data;
`ifdef ASYM_DPRAM_DOREG_EN
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) s1 <= SRVAL;
        else if (en && !hold) s1 <= sel;
    // set/reset acts on the output register; stage one keeps its read data
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) dout <= SRVAL;
        else dout <= (en && ssr) ? SRVAL : s1;
`else
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) s1 <= SRVAL;
        else if (en && (ssr || !hold)) s1 <= ssr ? SRVAL : sel;
    assign dout = s1;
`endif
endmodule

// File: rtl/asym_dpram.sv
// asym_dpram: dual-port RAM with a narrow port A and a RATIO-times wider port B over one
// wide-word array; ASYM_DPRAM_DOREG_EN adds an output register to each port.
module asym_dpram
    import ram_pkg::*;
#(
    parameter int WIDTH_A = 1,
    parameter int RATIO = 32,
    parameter int DEPTH_B = 512,
    parameter int MODE_A = MODE_WRITE_FIRST,
    parameter int MODE_B = MODE_WRITE_FIRST,
    parameter logic [WIDTH_A-1:0] SRVAL_A = '0,
    parameter logic [WIDTH_A*RATIO-1:0] SRVAL_B = '0
) (
    input logic clock,
    input logic reset_n,
    asym_dpram_if.slave bus
);
    localparam int WIDTH_B = WIDTH_A * RATIO;
    localparam int LW = clog2(RATIO);
    localparam int LWS = LW > 0 ? LW : 1;
    localparam int AW = clog2(DEPTH_B * RATIO);
    localparam int BW = clog2(DEPTH_B);
    logic [WIDTH_B-1:0] mem [DEPTH_B];
    logic [BW-1:0] word_a;
    logic [LWS-1:0] lane_a;
    logic [WIDTH_A-1:0] rd_a;
    logic [WIDTH_B-1:0] rd_b;
    assign word_a = BW'(bus.addra >> LW);
    assign lane_a = LWS'(bus.addra & AW'(RATIO - 1));
    assign rd_a = mem[word_a][lane_a*WIDTH_A +: WIDTH_A];
    assign rd_b = mem[bus.addrb];
    // B lands first so that A's lane wins when both write the same word
    always_ff @(posedge clock)
        if (reset_n) begin
            if (bus.enb && bus.web) mem[bus.addrb] <= bus.dib;
            if (bus.ena && bus.wea) mem[word_a][lane_a*WIDTH_A +: WIDTH_A] <= bus.dia;
        end
    asym_dpram_port #(.W(WIDTH_A), .MODE(MODE_A), .SRVAL(SRVAL_A)) port_a (
        .clock(clock), .reset_n(reset_n), .en(bus.ena), .we(bus.wea), .ssr(bus.ssra),
        .wr_data(bus.dia), .rd_data(rd_a), .dout(bus.doa)
    );
    asym_dpram_port #(.W(WIDTH_B), .MODE(MODE_B), .SRVAL(SRVAL_B)) port_b (
        .clock(clock), .reset_n(reset_n), .en(bus.enb), .we(bus.web), .ssr(bus.ssrb),
        .wr_data(bus.dib), .rd_data(rd_b), .dout(bus.dob)
    );
endmodule

// File: tb/tb_asym_dpram.sv
// tb_asym_dpram: three instances (write-first, read-first, no-change) share one random
// stimulus stream and are checked every cycle against a word-array model of the RAM.
module tb_asym_dpram;
    import ram_pkg::*;
`ifdef ASYM_DPRAM_DOREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam logic SRA = 1'b1;
    localparam logic [31:0] SRB = 32'hA5A5_A5A5;
    logic clock = 1'b0, reset_n = 1'b1;
    logic ena = 0, wea = 0, ssra = 0, enb = 0, web = 0, ssrb = 0;
    logic [0:0] dia = '0;
    logic [13:0] addra = '0;
    logic [31:0] dib = '0;
    logic [8:0] addrb = '0;
    logic doa_v [3];
    logic [31:0] dob_v [3];
    logic [31:0] mm [512];
    logic oa [3], sa [3];
    logic [31:0] ob [3], sb [3];
    logic ra, va, nca, ncb;
    logic [31:0] rb, vb, w27;
    int checks = 0, failures = 0;
    bit chk_en = 0;

    always #5 clock = ~clock;

    for (genvar k = 0; k < 3; k++) begin : g
        asym_dpram_if #(.WIDTH_A(1), .RATIO(32), .DEPTH_B(512)) bus ();
        assign bus.dia = dia;
        assign bus.addra = addra;
        assign bus.ena = ena;
        assign bus.wea = wea;
        assign bus.ssra = ssra;
        assign bus.dib = dib;
        assign bus.addrb = addrb;
        assign bus.enb = enb;
        assign bus.web = web;
        assign bus.ssrb = ssrb;
        assign doa_v[k] = bus.doa;
        assign dob_v[k] = bus.dob;
        asym_dpram #(.MODE_A(k), .MODE_B(k), .SRVAL_A(SRA), .SRVAL_B(SRB)) dut (
            .clock(clock), .reset_n(reset_n), .bus(bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Model: instance index k equals its write mode for both ports
    always @(negedge reset_n)
        for (int k = 0; k < 3; k++) begin
            oa[k] = SRA; sa[k] = SRA; ob[k] = SRB; sb[k] = SRB;
        end

    always @(posedge clock)
        if (reset_n) begin
            ra = mm[addra / 32][addra % 32];
            rb = mm[addrb];
            for (int k = 0; k < 3; k++) begin
                va = (wea && k == MODE_WRITE_FIRST) ? dia[0] : ra;
                vb = (web && k == MODE_WRITE_FIRST) ? dib : rb;
                nca = wea && k == MODE_NO_CHANGE;
                ncb = web && k == MODE_NO_CHANGE;
                if (L == 1) begin
                    if (ena) oa[k] = ssra ? SRA : (nca ? oa[k] : va);
                    if (enb) ob[k] = ssrb ? SRB : (ncb ? ob[k] : vb);
                end else begin
                    oa[k] = (ena && ssra) ? SRA : sa[k];
                    ob[k] = (enb && ssrb) ? SRB : sb[k];
                    if (ena && !nca) sa[k] = va;
                    if (enb && !ncb) sb[k] = vb;
                end
            end
            if (enb && web) mm[addrb] = dib;
            if (ena && wea) mm[addra / 32][addra % 32] = dia[0];
        end

    always @(negedge clock)
        if (chk_en)
            for (int k = 0; k < 3; k++) begin
                check($sformatf("doa%0d", k), 32'(doa_v[k]), 32'(oa[k]));
                check($sformatf("dob%0d", k), dob_v[k], ob[k]);
            end

    task automatic idle();
        ena = 0; wea = 0; ssra = 0; enb = 0; web = 0; ssrb = 0;
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic wr_b(input logic [8:0] a, input logic [31:0] d);
        idle(); enb = 1; web = 1; addrb = a; dib = d;
        step();
    endtask
    task automatic rd_b(input logic [8:0] a);
        idle(); enb = 1; addrb = a;
        step();
        idle();
        step();
    endtask

    initial begin
        #1 reset_n = 0;
        #2;
        check("rst_doa", 32'(doa_v[0]), 32'(SRA));
        check("rst_dob", dob_v[1], SRB);
        @(posedge clock);
        #1 reset_n = 1;
        for (int w = 0; w < 8; w++) wr_b(9'(w), (w == 5) ? 32'hCAFE_F00D : $urandom);
        // write attempted on an edge while reset is held low must be dropped
        reset_n = 0;
        idle(); enb = 1; web = 1; addrb = 5; dib = 32'h1111_1111;
        step();
        reset_n = 1;
        idle();
        chk_en = 1;
        check("hold_srval", dob_v[0], SRB);
        rd_b(5);
        check("rst_nowrite", dob_v[0], 32'hCAFE_F00D);

        wr_b(0, 32'h0F3C_A5F0);
        w27 = 32'h0F3C_A5F0;
        for (int i = 0; i < 32 + L - 1; i++) begin
            idle();
            if (i < 32) begin ena = 1; addra = 14'(i); end
            step();
            if (i >= L - 1) begin
                check("r27", 32'(doa_v[0]), 32'(w27[i-L+1]));
                check("r27m", 32'(oa[0]), 32'(w27[i-L+1]));
            end
        end

        wr_b(3, 32'h0);
        for (int i = 0; i < 8; i++) begin
            idle(); ena = 1; wea = 1; dia = 1'b1; addra = 14'(96 + i);
            step();
        end
        rd_b(3);
        check("r28", dob_v[0], 32'h0000_00FF);
        check("r28m", ob[0], 32'h0000_00FF);

        idle(); enb = 1; web = 1; addrb = 2; dib = 32'hFFFF_FFFF;
        ena = 1; wea = 1; dia = 1'b0; addra = 14'(2 * 32 + 5);
        step();
        rd_b(2);
        check("r29", dob_v[0], 32'hFFFF_FFDF);
        check("r29rf", dob_v[1], 32'hFFFF_FFDF);

        wr_b(1, 32'h1234_5678);
        rd_b(1);
        wr_b(1, 32'hDEAD_BEEF);
        idle();
        step();
        check("r30_wf", dob_v[0], 32'hDEAD_BEEF);
        check("r30_rf", dob_v[1], 32'h1234_5678);
        check("r30_nc", dob_v[2], 32'h1234_5678);

        idle(); enb = 1; addrb = 1;
        step();
        reset_n = 0;
        #1;
        for (int k = 0; k < 3; k++) check("r31_rst", dob_v[k], SRB);
        #1 reset_n = 1;
        idle();
        step();
        check("r31_hold", dob_v[0], SRB);
        rd_b(1);
        check("r31_mem", dob_v[0], 32'hDEAD_BEEF);
        idle(); enb = 1; web = 1; ssrb = 1; addrb = 4; dib = 32'h55AA_55AA;
        step();
        for (int k = 0; k < 3; k++) check("r31_ssr", dob_v[k], SRB);
        rd_b(4);
        check("r31_wr", dob_v[0], 32'h55AA_55AA);

        for (int n = 0; n < 600; n++) begin
            ena = $urandom_range(0, 3) != 0;
            wea = 1'($urandom);
            ssra = $urandom_range(0, 7) == 0;
            dia = 1'($urandom);
            addra = 14'($urandom_range(0, 255));
            enb = $urandom_range(0, 3) != 0;
            web = 1'($urandom);
            ssrb = $urandom_range(0, 7) == 0;
            dib = $urandom;
            addrb = 9'($urandom_range(0, 7));
            step();
            if ($urandom_range(0, 63) == 0) begin
                reset_n = 0;
                #2 reset_n = 1;
            end
        end
        idle();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
